lfsr_seq_ctrl: RTL
==================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter: LEN_W, default 8, width of burst-length field.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  burst request; sampled only in IDLE.
REQ-005 abort  input  1  synchronous burst cancel.
REQ-006 seed  input  [1:26]  seed captured on accepted start.
REQ-007 len  input  [LEN_W-1:0]  number of words in burst, captured on accepted start.
REQ-008 lfsr_q  input  [1:26]  current state of the external 26-bit LFSR.
REQ-009 lfsr_load  output  1  synchronous load strobe to the LFSR.
REQ-010 lfsr_din  output  [1:26]  parallel load data to the LFSR.
REQ-011 word_out  output  [1:26]  pseudo-random word to consumer.
REQ-012 word_valid, word_ready  output / input  1 each  valid/ready handshake on word_out.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at burst completion or abort.

Function
REQ-015 FSM states: IDLE, LOAD, RUN, DONE; the block SHALL implement exactly these.
REQ-016 IDLE: start=1 at an edge -> latch seed and len, go to LOAD; otherwise stay.
REQ-017 LOAD: lfsr_load=1 and lfsr_din=latched seed for exactly one cycle; next state RUN, or DONE if len=0.
REQ-018 lfsr_load SHALL be 0 and lfsr_din SHALL hold the latched seed in all states except LOAD.
REQ-019 RUN: word register SHALL capture lfsr_q at an edge when (!word_valid || word_ready) and fewer than len words have been captured; word_valid set, capture count +1.
REQ-020 First captured word SHALL equal the seed (LFSR loaded at the LOAD->RUN edge); first word_valid 2 cycles after the start edge.
REQ-021 While word_valid=1 and word_ready=0, word_out SHALL hold stable; LFSR steps are skipped (not buffered).
REQ-022 Transfer = word_valid && word_ready at an edge; on the transfer of word number len, RUN -> DONE and word_valid cleared.
REQ-023 DONE: done=1 for one cycle, then IDLE; start during DONE ignored.
REQ-024 start in LOAD/RUN/DONE SHALL be ignored (no relatch).
REQ-025 abort=1 in LOAD or RUN -> DONE next edge, word_valid cleared, in-flight word dropped; abort has priority over capture and transfer; abort in IDLE ignored.
REQ-026 Capture counter width LEN_W+1; no wrap for any len value up to 2^LEN_W-1.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, lfsr_load=0, lfsr_din=0, word_out=0, word_valid=0, busy=0, done=0, counter=0, regardless of clk.
REQ-028 Reset mid-burst discards the burst; first legal start after rst_n rises SHALL begin a fresh burst.

Configuration
REQ-029 Macro LFSR_ZERO_SEED_GUARD_EN: when defined, an all-zero seed at accepted start SHALL be replaced by 26'h3FFFFFF, and lfsr_q=0 observed in RUN SHALL be treated as abort (-> DONE).
REQ-030 When LFSR_ZERO_SEED_GUARD_EN is undefined, seed SHALL be passed unchanged and zero lfsr_q captured as a normal word.

Verification
REQ-031 Reset: rst_n=0 asynchronously mid-RUN -> all outputs 0 before the next clk edge; busy=0.
REQ-032 Basic burst: seed=26'h3656B59, len=4, word_ready=1 -> lfsr_load one cycle, 4 words, first=26'h3656B59, each equal to lfsr_q of capture cycle, done pulse, IDLE.
REQ-033 Backpressure: len=3, word_ready=0 for 5 cycles on word 2 -> word_out stable 5 cycles, exactly 3 transfers, done once.
REQ-034 Abort/start collision: abort=1 on 2nd RUN cycle with start=1 -> DONE, done pulse, no relatch, IDLE; len=0 -> LOAD then DONE, no word_valid.
REQ-035 Zero seed: seed=0 with LFSR_ZERO_SEED_GUARD_EN -> lfsr_din=26'h3FFFFFF; without macro -> lfsr_din=0, words of 0 emitted.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// Burst sequencer for an external 26-bit LFSR: seeds it, then streams its states out over valid/ready.
// Optional build macro LFSR_ZERO_SEED_GUARD_EN substitutes an all-ones seed for zero and aborts on an all-zero LFSR state.
module lfsr_seq_ctrl #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:26]      seed,
  input  logic [LEN_W-1:0] len,
  input  logic [1:26]      lfsr_q,
  output logic             lfsr_load,
  output logic [1:26]      lfsr_din,
  output logic [1:26]      word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   cnt;
  logic [1:26]      seed_eff;
  logic             run_kill;
  logic             capture;
  logic             last_xfer;
  logic             in_run;

`ifdef LFSR_ZERO_SEED_GUARD_EN
  assign seed_eff = (seed == '0) ? '1 : seed;
  assign run_kill = abort || (lfsr_q == '0);
`else
  assign seed_eff = seed;
  assign run_kill = abort;
`endif

  assign in_run = (state == RUN);

  // The held word is always the most recent capture, so the final transfer is
  // the one that happens once the capture count has reached len.
  assign capture   = in_run && !run_kill && (!word_valid || word_ready)
                     && (cnt < {1'b0, len_q});
  assign last_xfer = in_run && !run_kill && word_valid && word_ready
                     && (cnt == {1'b0, len_q});

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (abort || (len_q == '0)) ? DONE : RUN;
      RUN:     if (run_kill || last_xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      lfsr_din   <= '0;
      cnt        <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        lfsr_din <= seed_eff;
        len_q    <= len;
        cnt      <= '0;
      end
      if (capture) begin
        word_out   <= lfsr_q;
        word_valid <= 1'b1;
        cnt        <= cnt + {{LEN_W{1'b0}}, 1'b1};
      end else if (in_run && (run_kill || last_xfer)) begin
        word_valid <= 1'b0;
      end
    end
  end

  assign lfsr_load = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
